// File: rtl/mempool_dram_burst_splitter.sv
// Splits AXI bursts at DRAM interleave chunk boundaries into per-controller sub-requests.
// Optional saturating statistics counters: define MEMPOOL_DRAM_SPLIT_STATS_EN.
module mempool_dram_burst_splitter #(
    parameter int unsigned NumDrams         = 4,
    parameter int unsigned BeatBytes        = 64,
    parameter int unsigned MaxInterleaveLog = 8,
    parameter int unsigned AddrWidth        = 32,
    parameter int unsigned IdWidth          = 4,
    parameter int unsigned LenWidth         = 8,
    localparam int unsigned IlogW = $clog2(MaxInterleaveLog + 1),
    localparam int unsigned CtrlW = (NumDrams > 1) ? $clog2(NumDrams) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [IlogW-1:0]     interleave_log_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [AddrWidth-1:0] req_addr_i,
    input  logic [LenWidth-1:0]  req_len_i,
    input  logic [IdWidth-1:0]   req_id_i,
    input  logic                 req_write_i,
    output logic                 sub_valid_o,
    input  logic                 sub_ready_i,
    output logic [CtrlW-1:0]     sub_ctrl_id_o,
    output logic [AddrWidth-1:0] sub_addr_o,
    output logic [LenWidth-1:0]  sub_len_o,
    output logic [IdWidth-1:0]   sub_id_o,
    output logic                 sub_write_o,
    output logic [LenWidth-1:0]  sub_idx_o,
    output logic                 sub_first_o,
    output logic                 sub_last_o,
`ifdef MEMPOOL_DRAM_SPLIT_STATS_EN
    input  logic                 stat_clear_i,
    output logic [31:0]          stat_bursts_o,
    output logic [31:0]          stat_splits_o,
`endif
    output logic                 busy_o
);

    localparam int unsigned BbLog = $clog2(BeatBytes);
    localparam int unsigned SB    = $clog2(NumDrams);
    localparam int unsigned BW    =
        ((MaxInterleaveLog > LenWidth) ? MaxInterleaveLog : LenWidth) + 2;
    localparam bit Split = (NumDrams > 1);

    typedef enum logic {
        IDLE,
        SPLIT
    } state_e;

    state_e               state_q;
    logic [AddrWidth-1:0] addr_q;
    logic [BW-1:0]        beats_q;
    logic [LenWidth-1:0]  idx_q;
    logic [IlogW-1:0]     ilog_q;
    logic [IdWidth-1:0]   id_q;
    logic                 write_q;

    logic [IlogW-1:0]     ilog_sat;
    logic [AddrWidth-1:0] beat_addr;
    logic [BW-1:0]        chunk_beats;
    logic [BW-1:0]        off;
    logic [BW-1:0]        chunk_rem;
    logic [BW-1:0]        sub_beats;
    logic [7:0]           cb;
    logic [AddrWidth-1:0] ctrl_full;
    logic [AddrWidth-1:0] low_mask;
    logic [AddrWidth-1:0] addr_adv;
    logic                 is_last;
    logic                 sub_hs;
    logic                 req_hs;

    assign ilog_sat = (interleave_log_i > IlogW'(MaxInterleaveLog))
                    ? IlogW'(MaxInterleaveLog) : interleave_log_i;

    assign beat_addr   = addr_q >> BbLog;
    assign chunk_beats = BW'(1) << ilog_q;
    assign off         = BW'(beat_addr) & (chunk_beats - BW'(1));
    assign chunk_rem   = chunk_beats - off;
    assign sub_beats   = (!Split || (beats_q <= chunk_rem)) ? beats_q : chunk_rem;
    assign is_last     = (beats_q == sub_beats);

    assign cb        = 8'(BbLog) + 8'(ilog_q);
    assign ctrl_full = addr_q >> cb;
    assign low_mask  = ~({AddrWidth{1'b1}} << cb);

    assign sub_valid_o   = (state_q == SPLIT);
    assign busy_o        = (state_q == SPLIT);
    assign sub_ctrl_id_o = Split ? ctrl_full[CtrlW-1:0] : '0;
    assign sub_addr_o    = ((addr_q >> (cb + 8'(SB))) << cb) | (addr_q & low_mask);
    assign sub_len_o     = LenWidth'(sub_beats - BW'(1));
    assign sub_id_o      = id_q;
    assign sub_write_o   = write_q;
    assign sub_idx_o     = idx_q;
    assign sub_first_o   = (idx_q == '0);
    assign sub_last_o    = is_last;

    assign sub_hs      = (state_q == SPLIT) && sub_ready_i;
    assign req_ready_o = (state_q == IDLE) || (sub_hs && is_last);
    assign req_hs      = req_valid_i && req_ready_o;

    // Dropping the byte offset makes every later sub-request chunk-aligned.
    assign addr_adv = (addr_q & ~AddrWidth'(BeatBytes - 1))
                    + (AddrWidth'(sub_beats) << BbLog);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            addr_q  <= '0;
            beats_q <= '0;
            idx_q   <= '0;
            ilog_q  <= '0;
            id_q    <= '0;
            write_q <= 1'b0;
        end else if (req_hs) begin
            state_q <= SPLIT;
            addr_q  <= req_addr_i;
            beats_q <= BW'(req_len_i) + BW'(1);
            idx_q   <= '0;
            ilog_q  <= ilog_sat;
            id_q    <= req_id_i;
            write_q <= req_write_i;
        end else if (sub_hs) begin
            if (is_last) begin
                state_q <= IDLE;
            end else begin
                addr_q  <= addr_adv;
                beats_q <= beats_q - sub_beats;
                idx_q   <= idx_q + LenWidth'(1);
            end
        end
    end

`ifdef MEMPOOL_DRAM_SPLIT_STATS_EN
    logic [31:0] bursts_q;
    logic [31:0] splits_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bursts_q <= '0;
            splits_q <= '0;
        end else if (stat_clear_i) begin
            bursts_q <= '0;
            splits_q <= '0;
        end else begin
            if (req_hs && (bursts_q != '1)) bursts_q <= bursts_q + 32'd1;
            if (sub_hs && !sub_first_o && (splits_q != '1)) splits_q <= splits_q + 32'd1;
        end
    end

    assign stat_bursts_o = bursts_q;
    assign stat_splits_o = splits_q;
`endif

endmodule

// File: tb/tb_mempool_dram_burst_splitter.sv
// Directed self-checking bench for mempool_dram_burst_splitter.
// NumDrams=4, BeatBytes=64; expected values hand-computed.
module tb_mempool_dram_burst_splitter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  ilog;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [7:0]  req_len;
    logic [3:0]  req_id;
    logic        req_write;
    logic        sub_valid;
    logic        sub_ready;
    logic [1:0]  sub_ctrl;
    logic [31:0] sub_addr;
    logic [7:0]  sub_len;
    logic [3:0]  sub_id;
    logic        sub_write;
    logic [7:0]  sub_idx;
    logic        sub_first;
    logic        sub_last;
    logic        busy;
`ifdef MEMPOOL_DRAM_SPLIT_STATS_EN
    logic        stat_clear;
    logic [31:0] stat_bursts;
    logic [31:0] stat_splits;
    assign stat_clear = 1'b0;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    mempool_dram_burst_splitter dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .interleave_log_i (ilog),
        .req_valid_i      (req_valid),
        .req_ready_o      (req_ready),
        .req_addr_i       (req_addr),
        .req_len_i        (req_len),
        .req_id_i         (req_id),
        .req_write_i      (req_write),
        .sub_valid_o      (sub_valid),
        .sub_ready_i      (sub_ready),
        .sub_ctrl_id_o    (sub_ctrl),
        .sub_addr_o       (sub_addr),
        .sub_len_o        (sub_len),
        .sub_id_o         (sub_id),
        .sub_write_o      (sub_write),
        .sub_idx_o        (sub_idx),
        .sub_first_o      (sub_first),
        .sub_last_o       (sub_last),
`ifdef MEMPOOL_DRAM_SPLIT_STATS_EN
        .stat_clear_i     (stat_clear),
        .stat_bursts_o    (stat_bursts),
        .stat_splits_o    (stat_splits),
`endif
        .busy_o           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] a, input logic [7:0] l, input logic [3:0] id);
        req_valid = 1'b1;
        req_addr  = a;
        req_len   = l;
        req_id    = id;
    endtask

    task automatic chk_sub(input string tag, input logic [1:0] c, input logic [31:0] a,
                           input logic [7:0] l, input logic [7:0] ix,
                           input logic f, input logic la);
        chk({tag, ".valid"}, sub_valid, 1'b1);
        chk({tag, ".ctrl"},  sub_ctrl, c);
        chk({tag, ".addr"},  sub_addr, a);
        chk({tag, ".len"},   sub_len, l);
        chk({tag, ".idx"},   sub_idx, ix);
        chk({tag, ".first"}, sub_first, f);
        chk({tag, ".last"},  sub_last, la);
    endtask

    initial begin
        rst_n     = 1'b0;
        ilog      = 4'd4;
        req_valid = 1'b0;
        req_addr  = '0;
        req_len   = '0;
        req_id    = '0;
        req_write = 1'b0;
        sub_ready = 1'b0;
        #1;
        chk("rst.req_ready", req_ready, 1'b1);
        chk("rst.sub_valid", sub_valid, 1'b0);
        chk("rst.busy", busy, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Scenario 1: single sub
        send(32'h400, 8'd3, 4'd2);
        chk("s1.ready_idle", req_ready, 1'b1);
        tick();
        req_valid = 1'b0;
        chk_sub("s1", 2'd1, 32'h0, 8'd3, 8'd0, 1'b1, 1'b1);
        chk("s1.busy", busy, 1'b1);
        chk("s1.id", sub_id, 4'd2);
        chk("s1.ready_stall", req_ready, 1'b0);

        // Scenario 4: back-to-back accept during last handshake
        sub_ready = 1'b1;
        req_write = 1'b1;
        send(32'hFC0, 8'd3, 4'd5);
        #1;
        chk("s4.ready_last", req_ready, 1'b1);
        tick();
        req_valid = 1'b0;
        sub_ready = 1'b0;
        chk_sub("s2.sub0", 2'd3, 32'h3C0, 8'd0, 8'd0, 1'b1, 1'b0);
        chk("s2.id", sub_id, 4'd5);
        chk("s2.write", sub_write, 1'b1);

        // Scenario 3: stall on sub0, outputs stable
        ilog = 4'd0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("s3.ctrl", sub_ctrl, 2'd3);
            chk("s3.addr", sub_addr, 32'h3C0);
            chk("s3.len", sub_len, 8'd0);
            chk("s3.ready", req_ready, 1'b0);
            chk("s3.valid", sub_valid, 1'b1);
        end
        ilog = 4'd4;
        sub_ready = 1'b1;
        tick();
        chk_sub("s2.sub1", 2'd0, 32'h400, 8'd2, 8'd1, 1'b0, 1'b1);
        tick();
        sub_ready = 1'b0;
        chk("s2.done_valid", sub_valid, 1'b0);
        chk("s2.done_busy", busy, 1'b0);

        // Scenario 5: async reset mid-split
        send(32'hFC0, 8'd3, 4'd1);
        tick();
        req_valid = 1'b0;
        chk("s5.valid_pre", sub_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("s5.valid_rst", sub_valid, 1'b0);
        chk("s5.busy_rst", busy, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("s5.ready_post", req_ready, 1'b1);
        chk("s5.valid_post", sub_valid, 1'b0);

        // Scenario 6: ilog saturation, change mid-burst ignored
        ilog = 4'd9;
        send(32'h0, 8'd255, 4'd3);
        tick();
        req_valid = 1'b0;
        chk_sub("s6", 2'd0, 32'h0, 8'd255, 8'd0, 1'b1, 1'b1);
        ilog = 4'd0;
        tick();
        chk("s6.len_hold", sub_len, 8'd255);
        chk("s6.last_hold", sub_last, 1'b1);
        sub_ready = 1'b1;
        tick();
        sub_ready = 1'b0;
        chk("s6.done", sub_valid, 1'b0);

        // Unaligned start: byte offset only in the first sub
        ilog = 4'd4;
        send(32'hFC8, 8'd1, 4'd0);
        tick();
        req_valid = 1'b0;
        sub_ready = 1'b1;
        chk_sub("ua.sub0", 2'd3, 32'h3C8, 8'd0, 8'd0, 1'b1, 1'b0);
        tick();
        chk_sub("ua.sub1", 2'd0, 32'h400, 8'd0, 8'd1, 1'b0, 1'b1);
        tick();
        sub_ready = 1'b0;
        chk("ua.done", busy, 1'b0);

        // ilog=0: 3-beat burst spreads across controllers
        ilog = 4'd0;
        send(32'h40, 8'd2, 4'd0);
        tick();
        req_valid = 1'b0;
        sub_ready = 1'b1;
        chk_sub("i0.sub0", 2'd1, 32'h0, 8'd0, 8'd0, 1'b1, 1'b0);
        tick();
        chk_sub("i0.sub1", 2'd2, 32'h0, 8'd0, 8'd1, 1'b0, 1'b0);
        tick();
        chk_sub("i0.sub2", 2'd3, 32'h0, 8'd0, 8'd2, 1'b0, 1'b1);
        tick();
        sub_ready = 1'b0;
        chk("i0.done", sub_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
